// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data bus access controller.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        MACC_IDLE = 2'b00,
        MACC_REQ  = 2'b01,
        MACC_WAIT = 2'b10,
        MACC_DONE = 2'b11
    } macc_state_t;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    // A data_ok only ends the transaction while one is outstanding; in REQ it needs addr_ok too.
    function automatic logic bus_complete(macc_state_t s, logic addr_ok, logic data_ok);
        return ((s == MACC_REQ) && addr_ok && data_ok) || ((s == MACC_WAIT) && data_ok);
    endfunction

endpackage

// File: rtl/mem_perf_cnt.sv
// Free-running 32-bit access and stall-cycle counters, wrapping at 2^32.
module mem_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        acc_inc,
    input  logic        wait_inc,
    output logic [31:0] acc_cnt,
    output logic [31:0] wait_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            if (acc_inc)  acc_cnt  <= acc_cnt + 32'd1;
            if (wait_inc) wait_cnt <= wait_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences MEM-stage loads/stores onto the req/addr_ok/data_ok data bus.
// Optional MEM_ACC_PERF_EN adds perf_acc_cnt/perf_wait_cnt outputs.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_req,
    input  logic                mem_wr,
    input  logic [1:0]          mem_size,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W/8-1:0] mem_wsel,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_exc,
    input  logic                flush,
    input  logic                pipe_hold,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_stall,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata
`ifdef MEM_ACC_PERF_EN
    ,
    output logic [31:0]         perf_acc_cnt,
    output logic [31:0]         perf_wait_cnt
`endif
);

    macc_state_t state, state_nxt;
    logic        drop;
    logic        issue;
    logic        accepted;
    logic        drop_now;
    logic        cap_rdata;

    always_ff @(posedge clk) begin
        if (rst) state <= MACC_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MACC_IDLE: if (issue) state_nxt = MACC_REQ;
            MACC_REQ: begin
                if (data_addr_ok && data_data_ok) state_nxt = drop_now ? MACC_IDLE : MACC_DONE;
                else if (data_addr_ok)            state_nxt = MACC_WAIT;
            end
            MACC_WAIT: if (data_data_ok) state_nxt = drop_now ? MACC_IDLE : MACC_DONE;
            MACC_DONE: if (flush || !pipe_hold) state_nxt = MACC_IDLE;
            default:   state_nxt = MACC_IDLE;
        endcase
    end

    always_comb begin
        data_req  = (state == MACC_REQ);
        mem_stall = mem_req && !mem_exc && !flush && (state != MACC_DONE);
        issue     = (state == MACC_IDLE) && mem_req && !mem_exc && !flush;
        accepted  = bus_complete(state, data_addr_ok, data_data_ok);
        // A flush arriving in the same cycle as data_ok must drop that result too.
        drop_now  = drop || flush;
        cap_rdata = accepted && !data_wr && !drop_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_wr    <= 1'b0;
            data_size  <= '0;
            data_addr  <= '0;
            data_wstrb <= '0;
            data_wdata <= '0;
        end else if (issue) begin
            data_wr    <= mem_wr;
            data_size  <= mem_size;
            data_addr  <= mem_addr;
            data_wstrb <= mem_wsel;
            data_wdata <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            mem_rdata <= '0;
        else if (cap_rdata) mem_rdata <= data_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst)            drop <= 1'b0;
        else if (accepted)  drop <= 1'b0;
        else if (flush && (state == MACC_REQ || state == MACC_WAIT)) drop <= 1'b1;
    end

`ifdef MEM_ACC_PERF_EN
    mem_perf_cnt u_perf (
        .clk      (clk),
        .rst      (rst),
        .acc_inc  (accepted),
        .wait_inc (mem_stall),
        .acc_cnt  (perf_acc_cnt),
        .wait_cnt (perf_wait_cnt)
    );
`endif

endmodule
